// File: rtl/sram_read_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sram_read_streamer_pkg                                 |
// | Description : Shared constants for the SRAM read streamer: default   |
// |               geometry, skid-buffer depth and FSM state encoding.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sram_read_streamer_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MEM_DEPTH  = 16;

  // Two entries cover the one word in the SRAM pipe plus one stalled word.
  localparam int SKID_DEPTH  = 2;
  localparam int c_OCC_WIDTH = $clog2(SKID_DEPTH + 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ISSUE  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN  = 2'd2;
  localparam logic [1:0] c_ST_FINISH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sram_read_streamer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sram_read_streamer_if                                  |
// | Description : Control, SRAM read-port and output-stream signals of   |
// |               the read streamer. master = streamer, slave = its      |
// |               surroundings (controller, SRAM, downstream stage).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface sram_read_streamer_if
  import sram_read_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) ();

  // transfer control
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  // SRAM read port
  logic                  sram_chip_en;
  logic                  sram_ren;
  logic [ADDR_WIDTH-1:0] sram_raddr;
  logic [DATA_WIDTH-1:0] sram_dout;
  // output stream
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, base_addr, len, sram_dout, out_ready,
    output busy, done, sram_chip_en, sram_ren, sram_raddr, out_data, out_valid
  );

  modport slave (
    output start, base_addr, len, sram_dout, out_ready,
    input  busy, done, sram_chip_en, sram_ren, sram_raddr, out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/sram_read_streamer_skid_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : skid_fifo2                                             |
// | Description : Two-entry synchronous FIFO. Head data comes straight   |
// |               from storage registers, so there is no path from       |
// |               push_data to head_data.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module skid_fifo2
  import sram_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  head_data,
  output logic [c_OCC_WIDTH-1:0] occ
);

  logic [DATA_WIDTH-1:0]  r_mem [SKID_DEPTH];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [c_OCC_WIDTH-1:0] r_occ;

  // Storage, pointers and occupancy; push+pop together leaves occupancy alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_occ <= r_occ + c_OCC_WIDTH'(1);
        2'b01:   r_occ <= r_occ - c_OCC_WIDTH'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign occ       = r_occ;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (r_occ == c_OCC_WIDTH'(SKID_DEPTH))));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (r_occ == '0)));

endmodule
`default_nettype wire

// File: rtl/sram_read_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sram_read_streamer                                     |
// | Description : Walks a contiguous SRAM address range and streams the  |
// |               read data out on valid/ready. Reads are only issued    |
// |               when the skid buffer can take the word, so the 1-cycle |
// |               SRAM latency never drops or duplicates data.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sram_read_streamer
  import sram_read_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_read_streamer_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic                   r_inflight;

  logic [c_OCC_WIDTH-1:0] w_occ;
  logic [DATA_WIDTH-1:0]  w_head;
  logic                   w_valid;
  logic                   w_pop;
  logic [c_OCC_WIDTH:0]   w_pending;
  logic                   w_credit_ok;
  logic                   w_ren;
  logic                   w_start_ok;
  logic                   w_drained;

  assign w_valid    = (w_occ != '0);
  assign w_pop      = w_valid & bus.out_ready;
  assign w_start_ok = bus.start & (bus.len != '0);

  // Words already owed to the buffer (stored + in the SRAM pipe) after this
  // cycle's pop; a new read is allowed only if that leaves room for it.
  assign w_pending   = (c_OCC_WIDTH + 1)'(w_occ) + (c_OCC_WIDTH + 1)'(r_inflight);
  assign w_credit_ok = w_pending < ((c_OCC_WIDTH + 1)'(SKID_DEPTH) + (c_OCC_WIDTH + 1)'(w_pop));
  assign w_ren       = (r_state == c_ST_ISSUE) && (r_remaining != '0) && w_credit_ok;

  // Buffer and pipe will both be empty at the next edge, so done can follow
  // the final handshake by exactly one cycle.
  assign w_drained = !r_inflight && ((w_occ == '0) || ((w_occ == c_OCC_WIDTH'(1)) && w_pop));

  // Next-state selection for the transfer sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.len == '0) ? c_ST_FINISH : c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        if (w_ren && (r_remaining == LEN_WIDTH'(1))) begin
          w_state_nxt = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = c_ST_FINISH;
        end
      end
      c_ST_FINISH: w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address/length counters: load on an accepted start, advance per issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if ((r_state == c_ST_IDLE) && w_start_ok) begin
      r_addr      <= bus.base_addr;
      r_remaining <= bus.len;
    end else if (w_ren) begin
      r_addr      <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
      r_remaining <= r_remaining - LEN_WIDTH'(1);
    end
  end

  // Marks the cycle in which the SRAM presents the word read last cycle;
  // clearing it on reset discards anything still in the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ren;
    end
  end

  skid_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_inflight),
    .push_data (bus.sram_dout),
    .pop       (w_pop),
    .head_data (w_head),
    .occ       (w_occ)
  );

  assign bus.busy         = (r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN);
  assign bus.done         = (r_state == c_ST_FINISH);
  assign bus.sram_ren     = w_ren;
  assign bus.sram_chip_en = w_ren;
  assign bus.sram_raddr   = r_addr;
  assign bus.out_valid    = w_valid;
  assign bus.out_data     = w_head;

endmodule
`default_nettype wire

// File: tb/tb_sram_read_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sram_read_streamer                                  |
// | Description : Scoreboard bench for sram_read_streamer with a         |
// |               registered-read SRAM model.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sram_read_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sram_read_streamer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LEN_WIDTH(5)) bus ();

  sram_read_streamer #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .MEM_DEPTH  (16),
    .LEN_WIDTH  (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [7:0] exp_q  [$];
  logic [3:0] addr_q [$];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int iss_cnt = 0;
  int hs_cnt = 0;
  int t_start = 0;
  int t_first = 0;
  int t_done = 0;
  int t_last_hs = 0;
  bit first_seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  // monitor scratch
  int  m_outstanding;
  bit  m_pop;
  bit  m_credit;
  int  m_aq_size;
  logic [7:0] m_e;
  logic [3:0] m_a;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Registered-read SRAM model.
  always @(posedge clk) begin
    if (bus.sram_ren) bus.sram_dout <= mem[bus.sram_raddr];
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: pops the scoreboard on every handshake and every SRAM read.
  always @(negedge clk) begin
    if (rst_n) begin
      m_pop         = bus.out_valid && bus.out_ready;
      m_outstanding = iss_cnt - hs_cnt;
      m_credit      = (m_outstanding - (m_pop ? 1 : 0)) < 2;
      m_aq_size     = addr_q.size();

      if (prev_stall)
        chk(bus.out_valid && (bus.out_data == prev_data), "stall_hold", int'(bus.out_data), int'(prev_data));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;

      if (bus.out_valid && !first_seen) begin
        first_seen = 1'b1;
        t_first    = cyc_cnt;
      end

      if (m_pop) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", int'(bus.out_data), -1);
        end else begin
          m_e = exp_q.pop_front();
          chk(bus.out_data == m_e, "out_data", int'(bus.out_data), int'(m_e));
        end
        hs_cnt++;
        t_last_hs = cyc_cnt;
      end

      if (bus.busy && (m_aq_size > 0))
        chk(bus.sram_ren == m_credit, "ren_credit", int'(bus.sram_ren), int'(m_credit));

      if (bus.sram_ren) begin
        chk(bus.sram_chip_en == 1'b1, "chip_en", int'(bus.sram_chip_en), 1);
        if (m_aq_size == 0) begin
          chk(1'b0, "unexpected_ren", int'(bus.sram_raddr), -1);
        end else begin
          m_a = addr_q.pop_front();
          chk(bus.sram_raddr == m_a, "sram_raddr", int'(bus.sram_raddr), int'(m_a));
        end
        iss_cnt++;
      end

      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        t_done = cyc_cnt;
        chk(!bus.busy, "busy_in_finish", int'(bus.busy), 0);
      end
    end else begin
      prev_stall = 1'b0;
      iss_cnt    = 0;
      hs_cnt     = 0;
    end
  end

  // One transfer: queue expectations, pulse start, drive the ready pattern,
  // optionally pulse a second (to be ignored) start, then check completion.
  task automatic run_xfer(input logic [3:0] base, input logic [4:0] n,
                          input logic [15:0] pat, input int pat_len, input int restart_at);
    int d0;
    int b0;
    int cyc;
    for (int i = 0; i < int'(n); i++) begin
      int a;
      a = (int'(base) + i) % 16;
      exp_q.push_back(mem[a]);
      addr_q.push_back(4'(a));
    end
    d0 = done_cnt;
    b0 = busy_cyc;
    first_seen = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.len = n;
    @(posedge clk); #1;
    t_start = cyc_cnt;
    cyc = 0;
    while ((done_cnt == d0) && (cyc < 200)) begin
      bus.start = (cyc == restart_at);
      if (cyc == restart_at) begin
        bus.base_addr = 4'd0;
        bus.len       = 5'd2;
      end
      bus.out_ready = (cyc < pat_len) ? pat[cyc] : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    chk(cyc < 200, "xfer_timeout", cyc, 200);
    chk(done_cnt == d0 + 1, "done_count", done_cnt - d0, 1);
    if (n != 0) begin
      chk(t_first - t_start == 2, "first_latency", t_first - t_start, 2);
      chk(t_done - t_last_hs == 1, "done_latency", t_done - t_last_hs, 1);
    end else begin
      chk(t_done == t_start, "zero_done_latency", t_done - t_start, 0);
      chk(busy_cyc == b0, "zero_busy", busy_cyc - b0, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);
    chk(exp_q.size() == 0, "words_left", exp_q.size(), 0);
    chk(addr_q.size() == 0, "addr_left", addr_q.size(), 0);
  endtask

  initial begin
    int d0;
    int h0;
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h50 + i * 7);
    mem[3] = 8'hA0; mem[4] = 8'hA1; mem[5] = 8'hA2; mem[6] = 8'hA3;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.out_ready = 1'b1; bus.sram_dout = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk(bus.busy == 1'b0,       "rst_busy",  int'(bus.busy), 0);
    chk(bus.done == 1'b0,       "rst_done",  int'(bus.done), 0);
    chk(bus.sram_ren == 1'b0,   "rst_ren",   int'(bus.sram_ren), 0);
    chk(bus.sram_chip_en == 1'b0, "rst_ce",  int'(bus.sram_chip_en), 0);
    chk(bus.out_valid == 1'b0,  "rst_valid", int'(bus.out_valid), 0);
    chk(bus.out_data == 8'h00,  "rst_data",  int'(bus.out_data), 0);
    chk(bus.sram_raddr == 4'd0, "rst_raddr", int'(bus.sram_raddr), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_xfer(4'd3,  5'd4,  16'hFFFF, 0,  -1);   // basic: A0..A3
    run_xfer(4'd14, 5'd4,  16'hFFFF, 0,  -1);   // wrap 14,15,0,1
    run_xfer(4'd8,  5'd6,  16'h03A7, 10, -1);   // 1,1 then 1,0,0,1,0,1,1,1
    run_xfer(4'd10, 5'd6,  16'h8421, 16, -1);   // long stalls, buffer fills
    run_xfer(4'd7,  5'd0,  16'hFFFF, 0,  -1);   // zero length
    run_xfer(4'd2,  5'd4,  16'hFFFF, 0,  2);    // start while busy ignored
    run_xfer(4'd9,  5'd16, 16'hFFFF, 0,  -1);   // full-depth transfer

    // reset in the middle of a 5-word transfer
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mem[5 + i]);
      addr_q.push_back(4'(5 + i));
    end
    d0 = done_cnt;
    h0 = hs_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 4'd5; bus.len = 5'd5; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while ((hs_cnt < h0 + 2) && (k < 50)) begin
      @(negedge clk); #2;
      k++;
    end
    chk(k < 50, "rst_wait_timeout", k, 50);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk(bus.out_valid == 1'b0, "midrst_valid", int'(bus.out_valid), 0);
    chk(bus.busy == 1'b0,      "midrst_busy",  int'(bus.busy), 0);
    chk(bus.sram_ren == 1'b0,  "midrst_ren",   int'(bus.sram_ren), 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(done_cnt == d0, "midrst_no_done", done_cnt - d0, 0);
    chk(bus.busy == 1'b0, "midrst_idle", int'(bus.busy), 0);

    run_xfer(4'd5, 5'd5, 16'hFFFF, 0, -1);     // fresh transfer after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
